// File: rtl/enc_pkg.sv
// Shared definitions for the encryption pipeline: word/key widths, LFSR taps
// and the small combinational helpers used by the stages.
package enc_pkg;

    localparam int WORD_W = 16;
    localparam int KEY_W  = 3;
    localparam logic [WORD_W-1:0] LFSR_TAPS = 16'hB400;

    // Rotate left by amt: the upper half of the doubled word shifted left.
    function automatic logic [WORD_W-1:0] rotl16(input logic [WORD_W-1:0] word,
                                                 input logic [KEY_W-1:0]  amt);
        logic [2*WORD_W-1:0] dbl;
        dbl = {word, word} << amt;
        return dbl[2*WORD_W-1:WORD_W];
    endfunction

    // Galois right-shift step.
    function automatic logic [WORD_W-1:0] lfsr_next(input logic [WORD_W-1:0] q);
        return q[0] ? ((q >> 1) ^ LFSR_TAPS) : (q >> 1);
    endfunction

    function automatic logic [WORD_W-1:0] static_ks(input logic [KEY_W-1:0] key);
        return {key, key, key, key, key, 1'b1};
    endfunction

endpackage

// File: rtl/enc_fifo.sv
// Show-ahead circular-buffer FIFO with explicit occupancy count.
// Storage resets to zero so the head reads as 0 after reset.
module enc_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             do_push;
    logic             do_pop;

    assign empty = (level_q == '0);
    assign full  = (level_q == LVL_W'(DEPTH));
    assign level = level_q;
    assign rdata = mem_q[rd_ptr_q];

    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/enc_stage2.sv
// Stage 2: rotate-and-XOR mix into a backpressure FIFO with sticky overflow.
// Define ENC_STAGE2_LFSR_EN to take the keystream from a Galois LFSR.
module enc_stage2
    import enc_pkg::*;
#(
    parameter int                DEPTH     = 4,
    parameter logic [WORD_W-1:0] LFSR_SEED = 16'hACE1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid_in,
    input  logic [WORD_W-1:0]      in_data,
    input  logic [KEY_W-1:0]       key_bits,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [WORD_W-1:0]      out_data,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] level
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("enc_stage2: DEPTH must be a power of two >= 2");
    end
    if (LFSR_SEED == '0) begin : g_bad_seed
        $error("enc_stage2: LFSR_SEED must be nonzero");
    end

    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              drop;
    logic [WORD_W-1:0] ks;
    logic [WORD_W-1:0] mixed;
    logic              overflow_q, overflow_d;

    // Upstream has no ready, so a word arriving at a full, non-draining FIFO is lost.
    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign push      = valid_in && (!fifo_full || pop);
    assign drop      = valid_in && fifo_full && !pop;
    assign mixed     = rotl16(in_data, key_bits) ^ ks;

`ifdef ENC_STAGE2_LFSR_EN
    logic [WORD_W-1:0] lfsr_q, lfsr_d;

    // The keystream only moves on words actually stored, so drops do not desync it.
    always_comb begin
        lfsr_d = lfsr_q;
        if (push) begin
            lfsr_d = lfsr_next(lfsr_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign ks = lfsr_q;
`else
    assign ks = static_ks(key_bits);
`endif

    always_comb begin
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;

    enc_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (mixed),
        .rdata (out_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

endmodule
